// File: rtl/lane_load_demux.sv
// Write-side lane distributor: takes a valid/ready word stream and emits one registered
// one-hot strobe plus shared data per beat, lane k receiving word k of each frame.
module lane_load_demux #(
    parameter int DATA_W    = 17,
    parameter int NUM_LANES = 32,
    parameter int IDX_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic [NUM_LANES-1:0] lane_we,
    output logic [DATA_W-1:0]    lane_data,
    output logic [IDX_W-1:0]     lane_idx,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_LANES-1:0] vec;
        vec      = {NUM_LANES{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IDX_W-1:0]     idx_r;
    logic [IDX_W-1:0]     idx_nxt_s;
    logic                 ready_s;
    logic                 accept_s;
    logic [NUM_LANES-1:0] lane_we_r;
    logic [DATA_W-1:0]    lane_data_r;
    logic [IDX_W-1:0]     lane_idx_r;
    logic                 busy_r;
    logic                 frame_done_r;

    // ready depends only on state and abort so the source never sees a valid->ready loop
    assign ready_s  = (state_r == ST_LOAD) & ~abort;
    assign accept_s = ready_s & in_valid;

    // Next-state and lane counter decode
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_LOAD;
                    idx_nxt_s   = IDX_ZERO;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = IDX_ZERO;
                end else if (in_valid) begin
                    idx_nxt_s = idx_r + IDX_ONE;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
    end

    // State and lane counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Registered lane outputs; data and index hold between accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_we_r    <= {NUM_LANES{1'b0}};
            lane_data_r  <= {DATA_W{1'b0}};
            lane_idx_r   <= IDX_ZERO;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            if (accept_s) begin
                lane_we_r   <= lane_onehot(idx_r);
                lane_data_r <= in_data;
                lane_idx_r  <= idx_r;
            end else begin
                lane_we_r   <= {NUM_LANES{1'b0}};
                lane_data_r <= lane_data_r;
                lane_idx_r  <= lane_idx_r;
            end
            // one cycle behind DONE so it never overlaps the last lane's strobe
            frame_done_r <= (state_r == ST_DONE);
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    assign in_ready   = ready_s;
    assign lane_we    = lane_we_r;
    assign lane_data  = lane_data_r;
    assign lane_idx   = lane_idx_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_lane_load_demux.sv
// Directed bench for lane_load_demux: a behavioural FSM model predicts ready/done/busy,
// and a scoreboard queue carries each accepted word to the strobe it must produce.
module tb_lane_load_demux;

    typedef struct packed {
        logic [4:0]  idx;
        logic [16:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [16:0] in_data;
    logic        in_ready;
    logic [31:0] lane_we;
    logic [16:0] lane_data;
    logic [4:0]  lane_idx;
    logic        busy;
    logic        frame_done;

    exp_t        sb_q[$];
    int          n_chk;
    int          n_fail;
    int          strobes;
    logic [1:0]  m_state;
    logic [4:0]  m_idx;
    logic        m_fd;
    logic [16:0] last_data;
    logic [4:0]  last_idx;

    lane_load_demux #(.DATA_W(17), .NUM_LANES(32), .IDX_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .lane_we(lane_we), .lane_data(lane_data), .lane_idx(lane_idx),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state   = 2'd0;
        m_idx     = 5'd0;
        m_fd      = 1'b0;
        last_data = 17'd0;
        last_idx  = 5'd0;
        sb_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_we"},   {32'd0, lane_we}, 64'd0);
        chk({tag, "_data"}, {47'd0, lane_data}, 64'd0);
        chk({tag, "_idx"},  {59'd0, lane_idx}, 64'd0);
        chk({tag, "_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    // One clock of stimulus: predict, push accepted word, clock, pop and compare
    task automatic step(input logic v, input logic [16:0] d, input logic s, input logic a);
        exp_t e;
        logic m_rdy;
        logic acc;
        in_valid = v;
        in_data  = d;
        start    = s;
        abort    = a;
        #1;
        m_rdy = (m_state == 2'd1) && !a;
        chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
        acc = m_rdy && v;
        if (acc) sb_q.push_back('{idx: m_idx, data: d});
        @(posedge clk);
        #1;
        m_fd = (m_state == 2'd2);
        case (m_state)
            2'd0: if (s) begin m_state = 2'd1; m_idx = 5'd0; end
            2'd1: begin
                if (a) begin
                    m_state = 2'd0;
                    m_idx   = 5'd0;
                end else if (v) begin
                    if (m_idx == 5'd31) m_state = 2'd2;
                    m_idx = m_idx + 5'd1;
                end
            end
            default: begin m_state = 2'd0; m_idx = 5'd0; end
        endcase
        if (acc) begin
            chk("sb_nonempty", {63'd0, (sb_q.size() != 0)}, 64'd1);
            e = sb_q.pop_front();
            chk("lane_we",   {32'd0, lane_we}, {32'd0, (32'd1 << e.idx)});
            chk("lane_data", {47'd0, lane_data}, {47'd0, e.data});
            chk("lane_idx",  {59'd0, lane_idx}, {59'd0, e.idx});
            last_data = e.data;
            last_idx  = e.idx;
            strobes++;
        end else begin
            chk("lane_we_idle",   {32'd0, lane_we}, 64'd0);
            chk("lane_data_hold", {47'd0, lane_data}, {47'd0, last_data});
            chk("lane_idx_hold",  {59'd0, lane_idx}, {59'd0, last_idx});
        end
        chk("frame_done", {63'd0, frame_done}, {63'd0, m_fd});
        chk("busy", {63'd0, busy}, {63'd0, (m_state != 2'd0)});
    endtask

    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_all_zero(tag);
        model_clear();
        #2;
        rst_n = 1'b1;
        #1;
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        strobes  = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = 17'd0;
        model_clear();
        #2;
        check_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        chk("reset_ready", {63'd0, in_ready}, 64'd0);

        // valid in IDLE is ignored
        for (int i = 0; i < 5; i++) step(1'b1, 17'h0abcd, 1'b0, 1'b0);

        // full frame, then back-to-back backpressured frame
        strobes = 0;
        step(1'b0, 17'd0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) step(1'b1, 17'h10000 + 17'(k), 1'b0, 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        chk("full_strobes", 64'(strobes), 64'd32);
        strobes = 0;
        step(1'b0, 17'd0, 1'b1, 1'b0);
        for (int i = 0; i < 200 && m_state != 2'd2; i++)
            step((i % 4 == 0) || (i % 4 == 3), 17'($urandom), 1'b0, 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        chk("gap_strobes", 64'(strobes), 64'd32);

        // abort after 10 beats with valid held high
        strobes = 0;
        step(1'b0, 17'd0, 1'b1, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 17'h00100 + 17'(k), 1'b0, 1'b0);
        step(1'b1, 17'h1dead, 1'b0, 1'b1);
        step(1'b1, 17'h1beef, 1'b0, 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        chk("abort_strobes", 64'(strobes), 64'd10);

        // start+abort in IDLE starts; start at beat 7 ignored; abort in DONE ignored
        strobes = 0;
        step(1'b0, 17'd0, 1'b1, 1'b1);
        for (int k = 0; k < 32; k++) step(1'b1, 17'h05000 + 17'(k * 3), (k == 7), 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b1);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        chk("ctrl_strobes", 64'(strobes), 64'd32);

        // reset at beat 20, then a clean frame
        step(1'b0, 17'd0, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b1, 17'h0a000 + 17'(k), 1'b0, 1'b0);
        async_reset("reset_mid");
        strobes = 0;
        step(1'b0, 17'd0, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) step(1'b1, 17'h0c000 + 17'(k), 1'b0, 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        step(1'b0, 17'd0, 1'b0, 1'b0);
        chk("restart_strobes", 64'(strobes), 64'd32);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
